// File: rtl/alu_shifter_pipe.sv
// Pipelined shifter/rotator: SLL, SRL, SRA, ROL, ROR with one registered stage per amount bit.
// Rotate modes exist only when ALU_SHIFTER_ROTATE_EN is defined; otherwise they report illegal.
module alu_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W:0]   in_amount,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    typedef struct packed {
        logic             valid;
        logic             left;
        logic             rot;
        logic             ovr;
        logic             fill;
        logic             ill;
        logic [LOG2W-1:0] amt;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t decoded;
    stage_t st [0:LOG2W];
    stage_t last;
    logic   advance;

    // NOTE: in_ready is combinational from out_ready so a stalled consumer blocks new requests in the same cycle.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign last     = st[LOG2W];

    // One stage: shift by 2^k when amount bit k is set; right shifts shift in the fill bit.
    function automatic stage_t step(input stage_t s, input int k);
        stage_t           r;
        logic [LOG2W-1:0] a;
        logic [WIDTH-1:0] fill_mask;
        int               sh;
        r         = s;
        a         = s.amt >> k;
        sh        = 1 << k;
        fill_mask = {WIDTH{s.fill}} & ~({WIDTH{1'b1}} >> sh);
        if (a[0]) begin
            if (s.left) r.data = s.data << sh;
            else        r.data = (s.data >> sh) | fill_mask;
`ifdef ALU_SHIFTER_ROTATE_EN
            if (s.rot)
                r.data = r.data | (s.left ? (s.data >> (WIDTH - sh)) : (s.data << (WIDTH - sh)));
`endif
        end
        return r;
    endfunction

    // NOTE: every default is assigned first so no path through the case leaves a field unassigned (no latch).
    always_comb begin
        decoded       = '0;
        decoded.valid = in_valid;
        decoded.amt   = in_amount[LOG2W-1:0];
        decoded.data  = in_data;
        case (in_mode)
            MODE_SLL: decoded.left = 1'b1;
            MODE_SRL: decoded.left = 1'b0;
            MODE_SRA: decoded.fill = in_data[WIDTH-1];
`ifdef ALU_SHIFTER_ROTATE_EN
            MODE_ROL: begin
                decoded.left = 1'b1;
                decoded.rot  = 1'b1;
            end
            MODE_ROR: decoded.rot = 1'b1;
`endif
            default:  decoded.ill = 1'b1;
        endcase
        decoded.ovr = in_amount[LOG2W] && !decoded.rot;
    end

    // NOTE: the data registers are reset too, so nothing from before a reset can ever leak out.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)     st[0] <= '0;
        else if (advance) st[0] <= decoded;
    end

    for (genvar k = 1; k <= LOG2W; k++) begin : g_stage
        always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n)     st[k] <= '0;
            else if (advance) st[k] <= step(st[k-1], k - 1);
        end
    end

    // Final register applies illegal and overshoot overrides so the result leaves registered.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_illegal <= 1'b0;
        end else if (advance) begin
            out_valid   <= last.valid;
            out_illegal <= last.valid && last.ill;
            if (last.ill)      out_data <= '0;
            else if (last.ovr) out_data <= {WIDTH{last.fill}};
            else               out_data <= last.data;
        end
    end

endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Scoreboard bench for alu_shifter_pipe (WIDTH=32); rotate expectations follow ALU_SHIFTER_ROTATE_EN.
module tb_alu_shifter_pipe;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [5:0]  in_amount = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_shifter_pipe #(.WIDTH(32)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_illegal (out_illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic send(input string name, input logic [31:0] d, input logic [5:0] a,
                        input logic [2:0] m, input logic [31:0] ed, input logic ei);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_mode   = m;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s: in_ready stuck low, request not accepted", name);
            in_valid = 1'b0;
        end else begin
            e.name = name;
            e.data = ed;
            e.ill  = ei;
            sb.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic measure_latency(input string name);
        int edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            #2;
        end while (!out_valid && edges < 20);
        check(name, edges, 6);
    endtask

    // Monitor: pops the scoreboard on every consume and checks stall behaviour.
    initial begin : monitor
        exp_t        e;
        logic        prev_stall;
        logic [31:0] held;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (prev_stall) check("stall_hold_data", out_data, held);
                prev_stall = 1'b1;
                held       = out_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %h with nothing outstanding", out_data);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_data"}, out_data, e.data);
                    check({e.name, "_illegal"}, out_illegal, e.ill);
                end
            end
        end
    end

    initial begin : main
        int   g;
        logic saw;

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_illegal", out_illegal, 0);
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);

        send("sll_19_3", 32'h19, 6'd3, 3'b000, 32'h0000_00C8, 1'b0);
        measure_latency("latency_first");
        drain();

        send("sll_big_14",  32'h0024_39EB, 6'd14, 3'b000, 32'h0E7A_C000, 1'b0);
        send("sll_1_32",    32'h1,         6'd32, 3'b000, 32'h0,         1'b0);
        send("srl_1_32",    32'h1,         6'd32, 3'b001, 32'h0,         1'b0);
        send("sra_neg_4",   32'h8000_0000, 6'd4,  3'b010, 32'hF800_0000, 1'b0);
        send("sra_neg_40",  32'h8000_0000, 6'd40, 3'b010, 32'hFFFF_FFFF, 1'b0);
        send("srl_31",      32'h8000_0000, 6'd31, 3'b001, 32'h0000_0001, 1'b0);
        send("sra_pos_40",  32'h7FFF_FFFF, 6'd40, 3'b010, 32'h0,         1'b0);
        send("sra_0",       32'h8000_0001, 6'd0,  3'b010, 32'h8000_0001, 1'b0);
        send("sll_0",       32'hDEAD_BEEF, 6'd0,  3'b000, 32'hDEAD_BEEF, 1'b0);
        send("ill_101",     32'h0000_1234, 6'd1,  3'b101, 32'h0,         1'b1);
`ifdef ALU_SHIFTER_ROTATE_EN
        send("rol_8",       32'h1234_5678, 6'd8,  3'b011, 32'h3456_7812, 1'b0);
        send("ror_36",      32'h1234_5678, 6'd36, 3'b100, 32'h8123_4567, 1'b0);
        send("ror_0",       32'hDEAD_BEEF, 6'd0,  3'b100, 32'hDEAD_BEEF, 1'b0);
`else
        send("rol_8",       32'h1234_5678, 6'd8,  3'b011, 32'h0,         1'b1);
        send("ror_36",      32'h1234_5678, 6'd36, 3'b100, 32'h0,         1'b1);
`endif
        drain();

        // Back-pressure: ten back-to-back requests with a four-cycle stall mid-stream.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send($sformatf("bp%0d", i), 32'h3, i[5:0], 3'b000, 32'h3 << i, 1'b0);
            end
            begin
                repeat (9) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three requests in flight and the head result stalled at the output.
        out_ready = 1'b0;
        send("rst_a", 32'h1, 6'd1, 3'b000, 32'h2, 1'b0);
        send("rst_b", 32'h1, 6'd2, 3'b000, 32'h4, 1'b0);
        send("rst_c", 32'h1, 6'd3, 3'b000, 32'h8, 1'b0);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            #2;
            g++;
        end
        check("inflight_out_valid", out_valid, 1);
        @(negedge clk);
        #4 clear_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_illegal", out_illegal, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        clear_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #2;
            if (out_valid) saw = 1'b1;
        end
        check("no_stale_result", saw, 0);

        send("post_rst_sll", 32'h19, 6'd3, 3'b000, 32'h0000_00C8, 1'b0);
        measure_latency("latency_post_reset");
        send("ill_110", 32'hFFFF_FFFF, 6'd5, 3'b110, 32'h0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_shifter_pipe.md
# alu_shifter_pipe

Pipelined, parametrised shifter/rotator for the ALU datapath. It generalises the 32-bit combinational left shifter to any power-of-two width and five shift modes, with one registered stage per shift-amount bit. A valid/ready handshake with full back-pressure sits between the operand latches and the ALU result mux. One operation can be accepted per cycle.

## Interface
- `WIDTH`, default 32: data width; must be a power of two, at least 4.
- `LOG2W`, default $clog2(WIDTH): number of shift stages; derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `clear_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request this cycle.
- `in_data` in WIDTH: operand.
- `in_amount` in LOG2W+1: shift amount, unsigned, range 0..2·WIDTH−1.
- `in_mode` in 3: operation select.
  - 000 SLL
  - 001 SRL
  - 010 SRA
  - 011 ROL
  - 100 ROR
  - 101–111 illegal
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out WIDTH: result.
- `out_illegal` out 1: the mode of this result was illegal; qualified by `out_valid`.

## Operation
- Transfer rules:
  - A request is accepted on a rising edge when `in_valid && in_ready`.
  - A result is consumed when `out_valid && out_ready`.
- Pipeline structure:
  - Stage 0 registers the operand, the mode, the low LOG2W amount bits, an overshoot flag and the fill bit.
  - Stages 1..LOG2W each conditionally shift by 2^(k−1) according to amount bit k−1.
- Global advance: `advance = !out_valid || out_ready`.
  - All stages load together when `advance` is high and hold otherwise.
  - `in_ready = advance`.
  - Bubbles propagate with their valid bit low.
- Arithmetic rules:
  - SLL and SRL fill with 0.
  - SRA fills with `in_data[WIDTH-1]`.
  - ROL and ROR use the amount modulo WIDTH; `in_amount[LOG2W]` is ignored.
- Overshoot, `in_amount >= WIDTH`:
  - SLL and SRL give all zeros.
  - SRA gives all copies of the sign bit.
  - Rotates are unaffected.
- An amount of 0 returns the operand unchanged for every legal mode.
- Illegal mode: `out_data = 0` and `out_illegal = 1`. The request still occupies a slot and still completes in order.
- Reset values, with `clear_n` low at any time including mid-operation:
  - every valid bit = 0 and every data register = 0;
  - `out_valid = 0`, `out_data = 0`, `out_illegal = 0`;
  - `in_ready = 1` from the first cycle after release.
  - In-flight requests are discarded with no partial result.
- No reordering.

## Timing
- Latency is LOG2W+1 cycles from the accept edge to `out_valid` high (6 for WIDTH=32), when no stall occurs.
- Throughput is 1 result per cycle while `out_ready` is held high.
- Stall: `out_ready` low while `out_valid` is high.
  - `out_data` and `out_illegal` hold stable.
  - `in_ready` is low in the same cycle (combinational from `out_ready`).
- A simultaneous accept and consume in one cycle is legal; there is no bubble insertion.
- All outputs except `in_ready` are registered.
- The critical path is one 2:1 mux level per stage plus the advance enable.

## Configuration
- `ALU_SHIFTER_ROTATE_EN` defined:
  - Modes 011 (ROL) and 100 (ROR) operate as specified.
- `ALU_SHIFTER_ROTATE_EN` not defined:
  - Rotate logic is removed.
  - Modes 011 and 100 are treated as illegal: `out_data = 0`, `out_illegal = 1`, same latency.
- The port list is identical in both builds.

## Test plan
- WIDTH=32, SLL: `in_data` 0x19, amount 3 → `out_data` 0xC8 (200) after exactly 6 cycles, `out_illegal` 0. Then 0x2439EB SLL 14 → 0x90E7AC000 truncated to 32 bits = 0x0E7AC000.
- SLL and SRL of 0x1 with amount 32 → 0x00000000.
- SRA of 0x80000000 with amount 4 → 0xF8000000; SRA with amount 40 → 0xFFFFFFFF. SRL of 0x80000000 with amount 31 → 0x00000001.
- With `ALU_SHIFTER_ROTATE_EN` defined: ROL 0x12345678 by 8 → 0x34567812; ROR by 36 → 0x81234567. Without the macro, the same two requests → 0, `out_illegal` 1.
- Back-pressure:
  - Stimulus: stream 10 back-to-back SLL requests (amount = index) with `out_ready` held low for 4 cycles mid-stream.
  - Required: all 10 results arrive in order with none lost or duplicated; `out_data` stays stable while stalled; `in_ready` is low during the stall.
- Reset mid-operation:
  - Stimulus: drop `clear_n` with 3 requests in flight.
  - Required: `out_valid` goes to 0 immediately (asynchronously) and no stale result appears after release. The first new request returns its correct value after 6 cycles. Mode 110 → `out_illegal` 1, `out_data` 0.
